// File: rtl/enemy_ship.sv
// enemy_ship: opposing craft for the player ship.
// It spawns at the right edge of the field at a pseudo-random height and flies
// left, one pixel every step period. Each tick it checks for overlap with the
// player ship's centre and reports hits and escapes to the score logic. It also
// drives its own pixel-enable and colour into the VGA pixel mux.
// Optional feature macro: ENEMY_SPEEDUP_EN. When it is defined, every hit
// shortens the step period by one tick, down to a floor of one tick.
module enemy_ship #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int ENEMY_W    = 30,
  parameter int ENEMY_H    = 20,
  parameter int SHIP_W     = 50,
  parameter int SHIP_H     = 20,
  parameter int STEP_DIV   = 2,
  parameter int HIT_MS     = 200,
  parameter int RESPAWN_MS = 500,
  parameter logic [9:0] LFSR_SEED = 10'h2A5
) (
  input  logic        clk_1ms,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [9:0]  x_ship,
  input  logic [9:0]  y_ship,
  output logic        enemy_on,
  output logic [11:0] rgb_enemy,
  output logic [9:0]  x_enemy,
  output logic [9:0]  y_enemy,
  output logic        hit,
  output logic        passed,
  output logic [7:0]  hit_count,
  output logic [3:0]  passed_count
);

  // FSM encoding
  localparam logic [1:0] SPAWN = 2'd0;
  localparam logic [1:0] MOVE  = 2'd1;
  localparam logic [1:0] HIT   = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  // Geometry constants, all derived from the parameters
  localparam logic [9:0]  X_SPAWN  = 10'(H_ACTIVE - ENEMY_W/2 - 1);
  localparam logic [9:0]  Y_RESET  = 10'(V_ACTIVE/2);
  localparam logic [9:0]  Y_SPAN   = 10'(V_ACTIVE - ENEMY_H);
  localparam logic [9:0]  HALF_EH  = 10'(ENEMY_H/2);
  localparam logic [9:0]  X_EXIT   = 10'(ENEMY_W/2);
  localparam logic [10:0] COLL_X   = 11'((ENEMY_W + SHIP_W)/2);
  localparam logic [10:0] COLL_Y   = 11'((ENEMY_H + SHIP_H)/2);
  localparam logic signed [11:0] BOX_HW = 12'(ENEMY_W/2);
  localparam logic signed [11:0] BOX_HH = 12'(ENEMY_H/2);
  localparam logic [15:0] HIT_LAST  = 16'(HIT_MS - 1);
  localparam logic [15:0] WAIT_LAST = 16'(RESPAWN_MS - 1);

  // Registers
  logic [1:0]  r_state;
  logic [9:0]  r_x_enemy;
  logic [9:0]  r_y_enemy;
  logic [9:0]  r_lfsr;
  logic [15:0] r_step;
  logic [15:0] r_timer;
  logic        r_hit;
  logic        r_passed;
  logic [7:0]  r_hit_count;
  logic [3:0]  r_passed_count;

  // Combinational nets
  logic [1:0]         w_state_next;
  logic               w_do_hit;
  logic               w_do_pass;
  logic               w_collide;
  logic [9:0]         w_lfsr_next;
  logic [9:0]         w_r;
  logic [9:0]         w_y_spawn;
  logic [15:0]        w_period;
  logic               w_step_last;
  logic signed [10:0] w_dx;
  logic signed [10:0] w_dy;
  logic [10:0]        w_adx;
  logic [10:0]        w_ady;
  logic signed [11:0] w_px;
  logic signed [11:0] w_py;
  logic signed [11:0] w_ex;
  logic signed [11:0] w_ey;
  logic               w_in_box;
  logic               w_visible;

  // ---------------------------------------------------------------------------
  // LFSR: 10-bit Fibonacci, x^10 + x^7 + 1, shifting toward the MSB.
  // ---------------------------------------------------------------------------
  assign w_lfsr_next[0] = r_lfsr[9] ^ r_lfsr[6];
  genvar gi;
  generate
    for (gi = 1; gi < 10; gi++) begin : g_lfsr_shift
      assign w_lfsr_next[gi] = r_lfsr[gi-1];
    end
  endgenerate

  // Advance the LFSR on every tick regardless of state
  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) r_lfsr <= LFSR_SEED;
    else        r_lfsr <= w_lfsr_next;
  end

  // Spawn height: fold the 9-bit random value into the playable band
  always_comb begin
    w_r = {1'b0, r_lfsr[8:0]};
    if (w_r < Y_SPAN) w_y_spawn = w_r + HALF_EH;
    else              w_y_spawn = w_r - Y_SPAN + HALF_EH;
  end

  // ---------------------------------------------------------------------------
  // Step period: constant, or shortened by each hit when the speedup is built.
  // ---------------------------------------------------------------------------
`ifdef ENEMY_SPEEDUP_EN
  logic [3:0] r_period;

  // Each hit shortens the step period by one tick, never below one tick
  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset)                         r_period <= 4'(STEP_DIV);
    else if (w_do_hit && r_period > 4'd1) r_period <= r_period - 4'd1;
  end

  assign w_period = {12'd0, r_period};
`else
  assign w_period = 16'(STEP_DIV);
`endif

  assign w_step_last = (r_step == w_period - 16'd1);

  // ---------------------------------------------------------------------------
  // Collision on registered positions, using 11-bit signed differences.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_dx  = $signed({1'b0, r_x_enemy}) - $signed({1'b0, x_ship});
    w_dy  = $signed({1'b0, r_y_enemy}) - $signed({1'b0, y_ship});
    w_adx = w_dx[10] ? $unsigned(-w_dx) : $unsigned(w_dx);
    w_ady = w_dy[10] ? $unsigned(-w_dy) : $unsigned(w_dy);
    w_collide = (w_adx < COLL_X) && (w_ady < COLL_Y);
  end

  // Next-state logic; a collision outranks an escape on the same tick
  always_comb begin
    w_state_next = r_state;
    w_do_hit     = 1'b0;
    w_do_pass    = 1'b0;
    case (r_state)
      SPAWN: w_state_next = MOVE;
      MOVE: begin
        if (w_collide) begin
          w_state_next = HIT;
          w_do_hit     = 1'b1;
        end else if (r_x_enemy <= X_EXIT) begin
          w_state_next = WAIT;
          w_do_pass    = 1'b1;
        end
      end
      HIT:  if (r_timer == HIT_LAST)  w_state_next = WAIT;
      WAIT: if (r_timer == WAIT_LAST) w_state_next = SPAWN;
      default: w_state_next = SPAWN;
    endcase
  end

  // State register
  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) r_state <= SPAWN;
    else        r_state <= w_state_next;
  end

  // Dwell timer for HIT and WAIT; restarts from zero on every state change
  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset)                                      r_timer <= 16'd0;
    else if (r_state != w_state_next)                r_timer <= 16'd0;
    else if (r_state == HIT || r_state == WAIT)      r_timer <= r_timer + 16'd1;
    else                                             r_timer <= 16'd0;
  end

  // Position and step counter; the craft freezes on the tick it leaves MOVE
  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      r_x_enemy <= X_SPAWN;
      r_y_enemy <= Y_RESET;
      r_step    <= 16'd0;
    end else begin
      case (r_state)
        SPAWN: begin
          r_x_enemy <= X_SPAWN;
          r_y_enemy <= w_y_spawn;
          r_step    <= 16'd0;
        end
        MOVE: begin
          if (!w_do_hit && !w_do_pass) begin
            if (w_step_last) begin
              r_step    <= 16'd0;
              r_x_enemy <= r_x_enemy - 10'd1;
            end else begin
              r_step <= r_step + 16'd1;
            end
          end
        end
        default: begin
          r_x_enemy <= r_x_enemy;
          r_y_enemy <= r_y_enemy;
          r_step    <= r_step;
        end
      endcase
    end
  end

  // One-tick event pulses for the score logic
  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      r_hit    <= 1'b0;
      r_passed <= 1'b0;
    end else begin
      r_hit    <= w_do_hit;
      r_passed <= w_do_pass;
    end
  end

  // Saturating event counters, updated on the same edge as their pulse
  always_ff @(posedge clk_1ms or negedge reset) begin
    if (!reset) begin
      r_hit_count    <= 8'd0;
      r_passed_count <= 4'd0;
    end else begin
      if (w_do_hit && r_hit_count != 8'hFF)     r_hit_count    <= r_hit_count + 8'd1;
      if (w_do_pass && r_passed_count != 4'hF)  r_passed_count <= r_passed_count + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Rendering: half-open box around the centre, signed so edges never wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_px = $signed({2'b00, x});
    w_py = $signed({2'b00, y});
    w_ex = $signed({2'b00, r_x_enemy});
    w_ey = $signed({2'b00, r_y_enemy});
    w_in_box = (w_px >= w_ex - BOX_HW) && (w_px < w_ex + BOX_HW) &&
               (w_py >= w_ey - BOX_HH) && (w_py < w_ey + BOX_HH);
    w_visible = (r_state == MOVE) || (r_state == HIT);
  end

  // Colour follows the state: green in flight, white while hit, dark otherwise
  always_comb begin
    case (r_state)
      MOVE:    rgb_enemy = 12'h0F0;
      HIT:     rgb_enemy = 12'hFFF;
      default: rgb_enemy = 12'h000;
    endcase
  end

  assign enemy_on     = w_visible && w_in_box;
  assign x_enemy      = r_x_enemy;
  assign y_enemy      = r_y_enemy;
  assign hit          = r_hit;
  assign passed       = r_passed;
  assign hit_count    = r_hit_count;
  assign passed_count = r_passed_count;

endmodule

// File: tb/tb_enemy_ship.sv
// tb_enemy_ship: directed bench for enemy_ship with default parameters.
// Expected hit/escape events are queued when a scenario is set up and popped
// when the DUT pulses hit or passed. Spawn heights come from a bench LFSR model.
module tb_enemy_ship;

  logic        clk_1ms = 1'b0;
  logic        reset   = 1'b0;
  bit          clk_run = 1'b1;
  logic [9:0]  x, y, x_ship, y_ship;
  logic        enemy_on;
  logic [11:0] rgb_enemy;
  logic [9:0]  x_enemy, y_enemy;
  logic        hit, passed;
  logic [7:0]  hit_count;
  logic [3:0]  passed_count;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef ENEMY_SPEEDUP_EN
  localparam int PERIOD_AFTER_HIT = 1;
`else
  localparam int PERIOD_AFTER_HIT = 2;
`endif

  typedef struct packed {
    logic       is_hit;
    logic [9:0] xe;
    logic [7:0] cnt;
  } ev_t;

  ev_t exp_q[$];

  enemy_ship dut (
    .clk_1ms(clk_1ms), .reset(reset), .x(x), .y(y),
    .x_ship(x_ship), .y_ship(y_ship), .enemy_on(enemy_on),
    .rgb_enemy(rgb_enemy), .x_enemy(x_enemy), .y_enemy(y_enemy),
    .hit(hit), .passed(passed), .hit_count(hit_count),
    .passed_count(passed_count)
  );

  // Gated clock so reset can be applied with no edges present
  always #5 if (clk_run) clk_1ms = ~clk_1ms;

  // Reference LFSR: x^10 + x^7 + 1 from seed 0x2A5, one shift per tick
  logic [9:0] m_lfsr;
  always @(posedge clk_1ms or negedge reset) begin
    if (!reset) m_lfsr <= 10'h2A5;
    else        m_lfsr <= {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  end

  function automatic logic [9:0] spawn_y(input logic [9:0] l);
    logic [9:0] r;
    r = {1'b0, l[8:0]};
    return (r < 10'd460) ? r + 10'd10 : r - 10'd450;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
    $display("[TB] check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Wait for a hit/passed pulse, then compare it with the head of the queue
  task automatic wait_event(input int max_cycles);
    bit  seen;
    ev_t e;
    seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk_1ms);
      if (hit || passed) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    assert (seen) else begin
      n_fail++;
      $error("FAIL event_timeout: observed no pulse expected a pulse within %0d ticks", max_cycles);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (seen) begin
        chk("event_is_hit", {31'd0, hit}, {31'd0, e.is_hit});
        chk("event_is_passed", {31'd0, passed}, {31'd0, !e.is_hit});
        chk("event_x_enemy", {22'd0, x_enemy}, {22'd0, e.xe});
        chk(e.is_hit ? "hit_count" : "passed_count",
            e.is_hit ? {24'd0, hit_count} : {28'd0, passed_count}, {24'd0, e.cnt});
        @(negedge clk_1ms);
        chk("pulse_one_tick", {31'd0, hit | passed}, 32'd0);
      end
    end
  endtask

  // Count consecutive sampled ticks showing colour val, starting with the current sample
  task automatic count_rgb(input logic [11:0] val, input int max_cycles,
                           output int n, output logic [9:0] snap, output bit vis);
    n = 0;
    vis = 1'b0;
    snap = m_lfsr;
    while (n < max_cycles && rgb_enemy === val) begin
      if (enemy_on) vis = 1'b1;
      snap = m_lfsr;
      n++;
      @(negedge clk_1ms);
    end
  endtask

  initial begin
    int         n;
    logic [9:0] snap;
    bit         vis;

    x = 10'd624; y = 10'd240; x_ship = 10'd45; y_ship = 10'd400;

    // ---------------- reset state ----------------
    repeat (3) @(negedge clk_1ms);
    chk("rst_x_enemy", {22'd0, x_enemy}, 32'd624);
    chk("rst_y_enemy", {22'd0, y_enemy}, 32'd240);
    chk("rst_enemy_on", {31'd0, enemy_on}, 32'd0);
    chk("rst_rgb", {20'd0, rgb_enemy}, 32'h000);
    chk("rst_hit_count", {24'd0, hit_count}, 32'd0);
    chk("rst_passed_count", {28'd0, passed_count}, 32'd0);
    chk("rst_pulses", {30'd0, hit, passed}, 32'd0);

    // ---------------- escape scenario, ship at (45,400) ----------------
    reset = 1'b1;
    exp_q.push_back('{is_hit: 1'b0, xe: 10'd15, cnt: 8'd1});
    @(negedge clk_1ms);  // first edge performed SPAWN (r = 0x0A5)
    chk("spawn_y", {22'd0, y_enemy}, 32'd175);
    chk("spawn_x", {22'd0, x_enemy}, 32'd624);
    chk("move_rgb", {20'd0, rgb_enemy}, 32'h0F0);
    // Render box around (624,175): x in [609,639), y in [165,185)
    x = 10'd609; y = 10'd165; #1 chk("box_top_left", {31'd0, enemy_on}, 32'd1);
    x = 10'd638; y = 10'd184; #1 chk("box_bot_right", {31'd0, enemy_on}, 32'd1);
    x = 10'd639; y = 10'd175; #1 chk("box_right_out", {31'd0, enemy_on}, 32'd0);
    x = 10'd624; y = 10'd185; #1 chk("box_bottom_out", {31'd0, enemy_on}, 32'd0);
    @(negedge clk_1ms);
    chk("move_tick1_x", {22'd0, x_enemy}, 32'd624);
    @(negedge clk_1ms);
    chk("move_tick2_x", {22'd0, x_enemy}, 32'd623);
    @(negedge clk_1ms);
    chk("move_tick3_x", {22'd0, x_enemy}, 32'd623);
    @(negedge clk_1ms);
    chk("move_tick4_x", {22'd0, x_enemy}, 32'd622);
    x = 10'd15; y = 10'd175;  // pixel on the frozen position during WAIT
    wait_event(3000);
    // Pulse tick was WAIT tick 1; remaining WAIT ticks plus the SPAWN tick are dark
    count_rgb(12'h000, 1000, n, snap, vis);
    chk("wait_dark_ticks", n, RESPAWN_MS_EXP() );
    chk("wait_invisible", {31'd0, vis}, 32'd0);
    chk("respawn_x", {22'd0, x_enemy}, 32'd624);
    chk("respawn_y", {22'd0, y_enemy}, {22'd0, spawn_y(snap)});
    chk("respawn_rgb", {20'd0, rgb_enemy}, 32'h0F0);

    // ---------------- collision scenario, ship at (45,175) ----------------
    @(negedge clk_1ms);
    reset = 1'b0; x_ship = 10'd45; y_ship = 10'd175;
    @(negedge clk_1ms);
    chk("rst2_passed_count", {28'd0, passed_count}, 32'd0);
    reset = 1'b1;
    exp_q.push_back('{is_hit: 1'b1, xe: 10'd84, cnt: 8'd1});
    x = 10'd84; y = 10'd175;
    wait_event(3000);
    chk("hit_rgb", {20'd0, rgb_enemy}, 32'hFFF);
    chk("hit_visible", {31'd0, enemy_on}, 32'd1);
    // Pulse tick was HIT tick 1, so HIT_MS-1 white ticks remain
    count_rgb(12'hFFF, 1000, n, snap, vis);
    chk("hit_white_ticks", n, 32'd199);
    count_rgb(12'h000, 1000, n, snap, vis);
    chk("hit_wait_dark_ticks", n, 32'd501);
    chk("hit_wait_invisible", {31'd0, vis}, 32'd0);
    chk("hit_respawn_x", {22'd0, x_enemy}, 32'd624);
    chk("hit_respawn_y", {22'd0, y_enemy}, {22'd0, spawn_y(snap)});
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk_1ms);
      chk("post_hit_step_x", {22'd0, x_enemy}, 624 - (c - 1) / PERIOD_AFTER_HIT);
    end

    // ---------------- asynchronous reset mid-HIT ----------------
    @(negedge clk_1ms);
    reset = 1'b0;
    @(negedge clk_1ms);
    reset = 1'b1;
    exp_q.push_back('{is_hit: 1'b1, xe: 10'd84, cnt: 8'd1});
    x = 10'd84; y = 10'd175;
    wait_event(3000);
    repeat (50) @(negedge clk_1ms);
    chk("midhit_visible", {31'd0, enemy_on}, 32'd1);
    clk_run = 1'b0;
    #20;
    reset = 1'b0;
    #1;
    chk("async_x_enemy", {22'd0, x_enemy}, 32'd624);
    chk("async_y_enemy", {22'd0, y_enemy}, 32'd240);
    chk("async_enemy_on", {31'd0, enemy_on}, 32'd0);
    chk("async_rgb", {20'd0, rgb_enemy}, 32'h000);
    chk("async_hit_count", {24'd0, hit_count}, 32'd0);
    clk_run = 1'b1;

    // ---------------- 16 escapes: passed_count saturates at 15 ----------------
    x_ship = 10'd1000; y_ship = 10'd1000;
    repeat (2) @(negedge clk_1ms);
    reset = 1'b1;
    for (int i = 1; i <= 16; i++)
      exp_q.push_back('{is_hit: 1'b0, xe: 10'd15, cnt: 8'((i > 15) ? 15 : i)});
    for (int i = 1; i <= 16; i++) wait_event(3000);
    chk("sat_passed_count", {28'd0, passed_count}, 32'd15);
    chk("sat_hit_count", {24'd0, hit_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Dark ticks after the escape pulse: WAIT ticks 2..RESPAWN_MS plus the SPAWN tick
  function automatic int RESPAWN_MS_EXP();
    return 500;
  endfunction

endmodule
